// File: rtl/wb_write_queue_if.sv
// Bundle for the write-back queue: producer stream, register-file write port,
// decode forwarding probes and occupancy.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;
    logic          we;

    logic [AW-1:0] rAddr1;
    logic [AW-1:0] rAddr2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;

    logic [CW-1:0] count;

    // Producer / decode / register-file side
    modport master (
        output in_valid, in_addr, in_data, rAddr1, rAddr2,
        input  in_ready, wAddr, wData, we,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );

    // Queue side
    modport slave (
        input  in_valid, in_addr, in_data, rAddr1, rAddr2,
        output in_ready, wAddr, wData, we,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register-file write port, one retire per cycle.
// Define WBQ_BYPASS_EN to build the decode forwarding search; otherwise fwd_* are tied to 0.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_write_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready looks only at occupancy, never at the retire happening this cycle
    assign bus.in_ready = !rst && !full;

    // Register 0 is hardwired: the handshake completes but nothing is stored
    assign push = bus.in_valid && bus.in_ready && (bus.in_addr != '0);

    // A reset cycle discards the pending head instead of writing it
    assign pop = !rst && !empty;

    assign bus.we    = pop;
    assign bus.wAddr = empty ? '0 : ent_addr[rd_ptr];
    assign bus.wData = empty ? '0 : ent_data[rd_ptr];
    assign bus.count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= bus.in_addr;
            ent_data[wr_ptr] <= bus.in_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    idx;
    logic             hit1;
    logic             hit2;
    logic [DW-1:0]    data1;
    logic [DW-1:0]    data2;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld <= '0;
        end else begin
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
            end
        end
    end

    // Walk oldest to newest so the newest match overwrites earlier ones
    always_comb begin
        idx   = '0;
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (ent_vld[idx] && (bus.rAddr1 != '0) && (ent_addr[idx] == bus.rAddr1)) begin
                hit1  = 1'b1;
                data1 = ent_data[idx];
            end
            if (ent_vld[idx] && (bus.rAddr2 != '0) && (ent_addr[idx] == bus.rAddr2)) begin
                hit2  = 1'b1;
                data2 = ent_data[idx];
            end
        end
    end

    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_data1 = data1;
    assign bus.fwd_hit2  = hit2;
    assign bus.fwd_data2 = data2;
`else
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vector table followed by a randomized run
// against a queue-based reference model of the write-back rules.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    wb_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        bit            r;
        bit            v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        bit            e_ready;
        bit            e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [CW-1:0] e_cnt;
        bit            e_h1;
        logic [DW-1:0] e_f1;
        bit            e_h2;
        logic [DW-1:0] e_f2;
    } vec_t;

    ent_t mq[$];
    int   n_checks;
    int   n_fail;
    int   dut_writes;
    int   model_writes;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Newest pending entry for a read address; the live input is not part of mq
    task automatic model_fwd(input logic [AW-1:0] ra, output bit hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (BYP && ra != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == ra) begin
                    hit  = 1'b1;
                    data = mq[i].d;
                    break;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check 1ns later, advance model at posedge
    task automatic cycle(input bit r, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input bit use_row, input vec_t row);
        bit            h1, h2, acc;
        logic [DW-1:0] f1, f2;
        rst          = r;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.rAddr1   = r1;
        bus.rAddr2   = r2;
        #1;
        model_fwd(r1, h1, f1);
        model_fwd(r2, h2, f2);
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !r && mq.size() < DEPTH});
        chk("we",       {31'b0, bus.we},       {31'b0, !r && mq.size() > 0});
        chk("wAddr",    DW'(bus.wAddr),        mq.size() > 0 ? DW'(mq[0].a) : '0);
        chk("wData",    bus.wData,             mq.size() > 0 ? mq[0].d : '0);
        chk("count",    DW'(bus.count),        DW'(mq.size()));
        chk("fwd_hit1", {31'b0, bus.fwd_hit1}, {31'b0, h1});
        chk("fwd_data1", bus.fwd_data1,        f1);
        chk("fwd_hit2", {31'b0, bus.fwd_hit2}, {31'b0, h2});
        chk("fwd_data2", bus.fwd_data2,        f2);
        if (use_row) begin
            chk("vec_ready", {31'b0, bus.in_ready}, {31'b0, row.e_ready});
            chk("vec_we",    {31'b0, bus.we},       {31'b0, row.e_we});
            chk("vec_waddr", DW'(bus.wAddr),        DW'(row.e_wa));
            chk("vec_wdata", bus.wData,             row.e_wd);
            chk("vec_count", DW'(bus.count),        DW'(row.e_cnt));
            chk("vec_hit1",  {31'b0, bus.fwd_hit1}, {31'b0, BYP && row.e_h1});
            chk("vec_fwd1",  bus.fwd_data1,         BYP ? row.e_f1 : '0);
            chk("vec_hit2",  {31'b0, bus.fwd_hit2}, {31'b0, BYP && row.e_h2});
            chk("vec_fwd2",  bus.fwd_data2,         BYP ? row.e_f2 : '0);
        end
        if (bus.we) dut_writes++;
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                model_writes++;
            end
            if (acc && a != '0) mq.push_back('{a: a, d: d});
        end
        @(negedge clk);
    endtask

    vec_t tbl[21];
    vec_t none;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        dut_writes   = 0;
        model_writes = 0;
        none         = '{default: '0};

        //          r v a  d       r1 r2 rdy we wa wd      cnt h1 f1      h2 f2
        tbl[0]  = '{1,0,0, 0,      0, 0, 0,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[1]  = '{0,1,3, 'h11,   3, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[2]  = '{0,0,0, 0,      3, 0, 1,  1, 3, 'h11,   1,  1, 'h11,   0, 0};
        tbl[3]  = '{0,0,0, 0,      3, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[4]  = '{0,1,0, 'hFF,   0, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[5]  = '{0,0,0, 0,      0, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[6]  = '{0,1,5, 'hA,    5, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[7]  = '{0,1,5, 'hB,    5, 0, 1,  1, 5, 'hA,    1,  1, 'hA,    0, 0};
        tbl[8]  = '{0,0,0, 0,      5, 5, 1,  1, 5, 'hB,    1,  1, 'hB,    1, 'hB};
        tbl[9]  = '{0,0,0, 0,      5, 5, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[10] = '{0,1,1, 1,      2, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[11] = '{0,1,2, 2,      2, 1, 1,  1, 1, 1,      1,  0, 0,      1, 1};
        tbl[12] = '{0,1,3, 3,      0, 0, 1,  1, 2, 2,      1,  0, 0,      0, 0};
        tbl[13] = '{0,1,4, 4,      0, 0, 1,  1, 3, 3,      1,  0, 0,      0, 0};
        tbl[14] = '{0,1,6, 6,      0, 0, 1,  1, 4, 4,      1,  0, 0,      0, 0};
        tbl[15] = '{0,0,0, 0,      0, 6, 1,  1, 6, 6,      1,  0, 0,      1, 6};
        tbl[16] = '{0,0,0, 0,      0, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[17] = '{0,1,7, 'h77,   0, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};
        tbl[18] = '{0,1,8, 'h88,   0, 0, 1,  1, 7, 'h77,   1,  0, 0,      0, 0};
        tbl[19] = '{1,1,9, 'h99,   0, 0, 0,  0, 8, 'h88,   1,  0, 0,      0, 0};
        tbl[20] = '{0,0,0, 0,      0, 0, 1,  0, 0, 0,      0,  0, 0,      0, 0};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.rAddr1   = '0;
        bus.rAddr2   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r1, tbl[i].r2, 1'b1, tbl[i]);
        end

        // Post-reset stale-entry sequence: several idle cycles must never retire r8
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, '0, 5'd8, 5'd9, 1'b0, none);
            chk("no_stale_we", {31'b0, bus.we}, 32'd0);
        end

        // Randomized traffic with occasional resets and register-0 writes
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 7)),
                  DW'($urandom),
                  AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)),
                  1'b0, none);
        end

        chk("retire_total", DW'(dut_writes), DW'(model_writes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
